// File: rtl/march_bist_ctrl.sv
// March C- memory BIST controller for a synchronous-read SRAM of 2^ADDR_W x DATA_W.
// Sequences addresses/data/strobes, checks read data one cycle later, records first-fail info.
module march_bist_ctrl #(
  parameter int                ADDR_W = 4,
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] BG     = {DATA_W{1'b0}},
  parameter int                CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop_on_fail,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [CNT_W-1:0]  fail_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;
  typedef enum logic {PH_RD, PH_WR} phase_e;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]        E_LAST   = 3'd5;

  state_e              state_q, state_d;
  phase_e              phase_q, phase_d;
  logic [2:0]          elem_q, elem_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                stop_q, stop_d;
  logic                fail_q, fail_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic [2:0]          fail_elem_q, fail_elem_d;
  logic [CNT_W-1:0]    fail_count_q, fail_count_d;
  logic                cmp_valid_q, cmp_valid_d;
  logic [DATA_W-1:0]   cmp_exp_q, cmp_exp_d;
  logic [ADDR_W-1:0]   cmp_addr_q, cmp_addr_d;
  logic [2:0]          cmp_elem_q, cmp_elem_d;
  logic                mismatch;
  logic                last_op_at_addr;
  logic                last_addr;

  function automatic logic elem_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  // Reads in E2/E4 expect the inverted background; writes in E1/E3 store it.
  function automatic logic rd_inverted(input logic [2:0] e);
    return (e == 3'd2) || (e == 3'd4);
  endfunction

  function automatic logic wr_inverted(input logic [2:0] e);
    return (e == 3'd1) || (e == 3'd3);
  endfunction

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latches).
  always_comb begin
    state_d         = state_q;
    phase_d         = phase_q;
    elem_d          = elem_q;
    addr_d          = addr_q;
    stop_d          = stop_q;
    fail_d          = fail_q;
    fail_addr_d     = fail_addr_q;
    fail_elem_d     = fail_elem_q;
    fail_count_d    = fail_count_q;
    cmp_valid_d     = 1'b0;
    cmp_exp_d       = cmp_exp_q;
    cmp_addr_d      = cmp_addr_q;
    cmp_elem_d      = cmp_elem_q;
    mem_addr        = '0;
    mem_wdata       = '0;
    mem_we          = 1'b0;
    mem_re          = 1'b0;
    last_op_at_addr = 1'b0;
    last_addr       = 1'b0;

    mismatch = cmp_valid_q && (mem_rdata != cmp_exp_q);
    if (mismatch) begin
      if (fail_count_q != '1) fail_count_d = fail_count_q + CNT_ONE;
      if (!fail_q) begin
        fail_d      = 1'b1;
        fail_addr_d = cmp_addr_q;
        fail_elem_d = cmp_elem_q;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_RUN;
          elem_d       = 3'd0;
          phase_d      = PH_WR;
          addr_d       = '0;
          stop_d       = stop_on_fail;
          fail_d       = 1'b0;
          fail_addr_d  = '0;
          fail_elem_d  = 3'd0;
          fail_count_d = '0;
        end
      end

      S_RUN: begin
        mem_addr = addr_q;
        if (phase_q == PH_RD) begin
          mem_re      = 1'b1;
          cmp_valid_d = 1'b1;
          cmp_exp_d   = rd_inverted(elem_q) ? ~BG : BG;
          cmp_addr_d  = addr_q;
          cmp_elem_d  = elem_q;
        end else begin
          mem_we    = 1'b1;
          mem_wdata = wr_inverted(elem_q) ? ~BG : BG;
        end

        last_op_at_addr = (phase_q == PH_WR) || (elem_q == E_LAST);
        last_addr       = elem_down(elem_q) ? (addr_q == '0) : (addr_q == '1);

        if (!last_op_at_addr) begin
          phase_d = PH_WR;
        end else if (last_addr) begin
          if (elem_q == E_LAST) begin
            state_d = S_DRAIN;
          end else begin
            elem_d  = elem_q + 3'd1;
            addr_d  = elem_down(elem_q + 3'd1) ? '1 : '0;
            phase_d = PH_RD;
          end
        end else begin
          addr_d  = elem_down(elem_q) ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
          phase_d = (elem_q == 3'd0) ? PH_WR : PH_RD;
        end

        // Abort: the op issued this cycle stands, nothing further is issued or compared.
        if (mismatch && stop_q) begin
          state_d     = S_DONE;
          cmp_valid_d = 1'b0;
        end
      end

      S_DRAIN: state_d = S_DONE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      phase_q      <= PH_WR;
      elem_q       <= 3'd0;
      addr_q       <= '0;
      stop_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_addr_q  <= '0;
      fail_elem_q  <= 3'd0;
      fail_count_q <= '0;
      cmp_valid_q  <= 1'b0;
      cmp_exp_q    <= '0;
      cmp_addr_q   <= '0;
      cmp_elem_q   <= 3'd0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      elem_q       <= elem_d;
      addr_q       <= addr_d;
      stop_q       <= stop_d;
      fail_q       <= fail_d;
      fail_addr_q  <= fail_addr_d;
      fail_elem_q  <= fail_elem_d;
      fail_count_q <= fail_count_d;
      cmp_valid_q  <= cmp_valid_d;
      cmp_exp_q    <= cmp_exp_d;
      cmp_addr_q   <= cmp_addr_d;
      cmp_elem_q   <= cmp_elem_d;
    end
  end

  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign fail       = fail_q;
  assign fail_addr  = fail_addr_q;
  assign fail_elem  = fail_elem_q;
  assign fail_count = fail_count_q;

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Self-checking bench for march_bist_ctrl: SRAM model with injectable faults,
// op-trace scoreboard built from the March C- element table, and end-of-run result checks.
module tb_march_bist_ctrl;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int CW = 2;
  localparam int N  = 1 << AW;

  typedef struct packed {
    logic          we;
    logic          re;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  logic          clk, rst, start, stop_on_fail;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we, mem_re, busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [CW-1:0] fail_count;

  int  n_checks = 0;
  int  n_errors = 0;
  int  fault_mode = 0;
  op_t exp_q[$];
  logic [DW-1:0] mem [0:N-1];

  march_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BG(8'h00), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop_on_fail(stop_on_fail),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_count(fail_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Fault 1: bit0 of address 5 stuck at 1. Fault 2: every word reads 0x00.
  function automatic logic [DW-1:0] faulty_read(input logic [DW-1:0] d, input logic [AW-1:0] a);
    if (fault_mode == 1 && a == 3'd5) return d | 8'h01;
    if (fault_mode == 2) return 8'h00;
    return d;
  endfunction

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= faulty_read(mem[mem_addr], mem_addr);
  end

  // Expected op trace straight from the element table; reads carry data 0.
  task automatic push_trace(input int max_ops);
    int rd_kind [6] = '{-1, 0, 1, 0, 1, 0};
    int wr_kind [6] = '{0, 1, 0, 1, 0, -1};
    bit down    [6] = '{0, 0, 0, 1, 1, 0};
    int n = 0;
    op_t o;
    exp_q.delete();
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < N; k++) begin
        logic [AW-1:0] a;
        a = down[e] ? AW'(N - 1 - k) : AW'(k);
        if (rd_kind[e] >= 0 && n < max_ops) begin
          o = {1'b0, 1'b1, a, 8'h00};
          exp_q.push_back(o);
          n++;
        end
        if (wr_kind[e] >= 0 && n < max_ops) begin
          o = {1'b1, 1'b0, a, (wr_kind[e] == 1) ? 8'hFF : 8'h00};
          exp_q.push_back(o);
          n++;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    op_t got, want;
    if (!rst && (mem_we || mem_re)) begin
      got = {mem_we, mem_re, mem_addr, (mem_we ? mem_wdata : 8'h00)};
      check("strobe_excl", {31'd0, mem_we & mem_re}, 32'd0);
      if (exp_q.size() == 0) begin
        check("extra_op", {19'd0, got}, 32'd0);
      end else begin
        want = exp_q.pop_front();
        check("op", {19'd0, got}, {19'd0, want});
      end
    end
  end

  task automatic run_test(input string tag, input int fmode, input logic sof, input bit poke,
                          input int trace_ops, input int exp_busy, input logic exp_fail,
                          input int exp_addr, input int exp_elem, input int exp_cnt);
    int busy_cycles = 0;
    bit seen = 0;
    fault_mode = fmode;
    push_trace(trace_ops);
    @(posedge clk); #1;
    start = 1'b1;
    stop_on_fail = sof;
    @(posedge clk); #1;
    start = 1'b0;
    stop_on_fail = 1'b0;
    check({tag, "_acc_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_acc_clear"}, {27'd0, done, fail, fail_count}, 32'd0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        seen = 1;
        break;
      end
      start = poke && (i == 10 || i == 45);
    end
    start = 1'b0;
    check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    check({tag, "_busy_cycles"}, busy_cycles, exp_busy);
    check({tag, "_fail"}, {31'd0, fail}, {31'd0, exp_fail});
    check({tag, "_fail_addr"}, {29'd0, fail_addr}, exp_addr);
    check({tag, "_fail_elem"}, {29'd0, fail_elem}, exp_elem);
    check({tag, "_fail_count"}, {30'd0, fail_count}, exp_cnt);
    repeat (3) @(negedge clk);
    check({tag, "_ops_left"}, exp_q.size(), 0);
    check({tag, "_done_hold"}, {30'd0, done, busy}, 32'd2);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    stop_on_fail = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_outputs",
          {8'd0, mem_addr, mem_wdata, mem_we, mem_re, busy, done, fail, fail_addr, fail_elem, fail_count},
          32'd0);

    run_test("clean",    0, 1'b0, 1'b0, 80, 81, 1'b0, 0, 0, 0);
    run_test("sa1",      1, 1'b0, 1'b0, 80, 81, 1'b1, 5, 1, 3);
    run_test("sa1_stop", 1, 1'b1, 1'b0, 20, 20, 1'b1, 5, 1, 1);
    run_test("stuck0",   2, 1'b0, 1'b0, 80, 81, 1'b1, 0, 2, 3);
    run_test("poke",     0, 1'b0, 1'b1, 80, 81, 1'b0, 0, 0, 0);

    // Reset mid-run: outputs must clear asynchronously and stay idle until a new start.
    fault_mode = 1;
    push_trace(80);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_outputs",
          {8'd0, mem_addr, mem_wdata, mem_we, mem_re, busy, done, fail, fail_addr, fail_elem, fail_count},
          32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("midrst_idle", {30'd0, busy, done}, 32'd0);
    end

    run_test("post_rst", 0, 1'b0, 1'b0, 80, 81, 1'b0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
